irq_controller: RTL
===================

Name: irq_controller

Overview:
- Parametrised interrupt controller that replaces fixed per-module IRQ bit wiring.
- Gathers up to 32 asynchronous peripheral interrupt sources and synchronises them.
- Per source: level/edge mode, polarity, enable and pending state.
- Drives one selected bit of the 6-bit CPU interrupt vector; software configures, inspects and claims interrupts through Bus_if-style slave signals.

Parameters:
- NUM_SOURCES, 16: number of source inputs; legal range 1..32.
- SYNC_STAGES, 2: synchroniser flop depth per source; legal range 2..4.
- IRQ_LINE, 0: index (0..5) of the interrupt vector bit driven.
- RESET_MODE, 32'h0: reset value of MODE (1 = edge, 0 = level).

Ports:
- clk  in  1  system clock (clk.base domain)
- rst_n  in  1  asynchronous active-low reset
- address  in  3  word offset of the register (bus address [4:2])
- read  in  1  read strobe
- write  in  1  write strobe
- data_wr  in  32  write data
- mask  in  4  byte-lane write enable; bit k covers data_wr[8k+7:8k]
- data_rd  out  32  read data
- stall  out  1  bus stall
- src  in  NUM_SOURCES  raw asynchronous interrupt sources
- interrupt  out  6  CPU interrupt vector; only bit IRQ_LINE is ever nonzero

Behaviour:
- Register map (word offsets):
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write.
  - 2 MODE: read/write.
  - 3 POLARITY: read/write; 1 = active-low.
  - 4 CLAIM: read only.
  - 5 RAW: read only; synchronised, polarity-adjusted inputs.
  - 6 SOFT_SET: optional feature only.
  - 7: reserved; reads 0, writes ignored.
- Bits at or above NUM_SOURCES read 0 and ignore writes.
- Reset values:
  - ENABLE = 0, POLARITY = 0, MODE = RESET_MODE, PENDING = 0.
  - Synchroniser and edge-history flops = 0.
  - data_rd = 0, stall = 0, interrupt = 0.
- Input path:
  - src passes through SYNC_STAGES flops, then XOR with POLARITY to give act[i].
  - An edge is act rising (0 to 1) versus the previous cycle's act.
- Level source (MODE[i] = 0): PENDING[i] = act[i] combinationally from registered act; W1C and claim have no effect.
- Edge source (MODE[i] = 1):
  - PENDING[i] is set on an edge; cleared by W1C or by a claim of source i.
  - A set and a clear in the same cycle: set wins, pending stays 1.
- Output: interrupt[IRQ_LINE] registered, = |(PENDING & ENABLE); all other bits 0.
- Latency: src edge to interrupt high is SYNC_STAGES + 2 cycles.
- CLAIM value:
  - Lowest index i with PENDING[i] & ENABLE[i], returned as i+1 (6-bit value, zero-extended).
  - 0 if none.
  - The read of CLAIM clears PENDING[i] when source i is edge mode.
- Writes:
  - Accepted in the cycle write = 1; stall stays 0; effect visible from the next cycle.
  - Byte lanes with mask bit 0 are unchanged.
  - A PENDING W1C honours the mask.
- Reads: single-wait-state handshake.
  - Cycle N (read first high): stall = 1, register value sampled.
  - Cycle N+1: stall = 0, data_rd valid; the master holds read/address until stall = 0.
  - data_rd holds its last value while idle.
  - The CLAIM side effect occurs exactly once, at the sample in cycle N.
- read and write together: write performed, read ignored, stall = 0.
- Changing MODE from edge to level discards edge-pending state; from level to edge, PENDING starts at 0.
- Changing POLARITY can create an edge; that edge is honoured.
- rst_n asserted mid-read: stall and data_rd drop to 0 immediately; any pending claim side effect is discarded.

Optional Feature:
- Macro: IRQC_SOFT_IRQ_EN.
- Defined:
  - Offset 6 SOFT_SET is write-only and reads 0.
  - Writing 1 sets PENDING[i] for edge-mode sources, mask honoured; writing it to a level-mode bit is ignored.
  - A soft set in the same cycle as a W1C of that bit: set wins.
- Undefined: offset 6 behaves as reserved, and no soft-set logic is generated.

Test Plan:
- Reset with NUM_SOURCES = 16, then read every offset → 0 except MODE = RESET_MODE; stall high exactly one cycle per read; interrupt = 6'b0.
- Level, active-high: ENABLE = 32'h0000_0008, raise src[3] → interrupt[0] = 1 after 4 cycles; drop src[3] → interrupt[0] = 0 after 4 cycles; read PENDING while high → 32'h8.
- Edge: MODE = 32'h0000_0030, ENABLE = 32'h30, pulse src[5] then src[4] → CLAIM reads 5, then 6, then 0; interrupt clears the cycle after the second claim completes.
- Polarity: POLARITY = 32'h1, MODE = 0, src[0] held at 0 → RAW bit0 = 1, PENDING = 32'h1.
- Masked W1C and race: write PENDING = 32'hFFFF_FFFF with mask 4'b0010 while src[9] (edge) rises in the same cycle → bit 9 stays set, bits 8 and 10–15 cleared, bits 0–7 untouched.
- With IRQC_SOFT_IRQ_EN and MODE = 32'h1: write SOFT_SET = 32'h3 → PENDING = 32'h1 (bit 1 is level mode, ignored); CLAIM returns 1 when ENABLE bit0 = 1.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: synchronised, per-source level/edge interrupt controller behind a word-addressed slave bus.
// Define IRQC_SOFT_IRQ_EN to add the write-only SOFT_SET register at offset 6.
module irq_controller #(
  parameter int          NUM_SOURCES = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int          IRQ_LINE    = 0,
  parameter logic [31:0] RESET_MODE  = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             address,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            data_wr,
  input  logic [3:0]             mask,
  output logic [31:0]            data_rd,
  output logic                   stall,
  input  logic [NUM_SOURCES-1:0] src,
  output logic [5:0]             interrupt
);

  function automatic logic [31:0] valid_bits(input int n);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = (i < n);
    return v;
  endfunction

  localparam logic [31:0] VALID = valid_bits(NUM_SOURCES);

  logic [31:0] src_ext;
  logic [31:0] sync_reg [SYNC_STAGES];
  logic [31:0] act, act_reg;
  logic [31:0] enable_reg, mode_reg, pol_reg;
  logic [31:0] pend_edge_reg, pend_edge_next;
  logic [31:0] pending, lane_bits, wr_mask, wr_bits;
  logic [31:0] set_bits, clr_bits, soft_bits, claim_onehot;
  logic [31:0] rd_value, data_rd_reg;
  logic [5:0]  claim_id;
  logic        rd_done_reg, rd_sample, irq_reg;

  always_comb begin
    src_ext = '0;
    src_ext[NUM_SOURCES-1:0] = src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
    end else begin
      sync_reg[0] <= src_ext;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  // act is the live comparison point for edges; act_reg is both the edge history and the level value.
  assign act     = sync_reg[SYNC_STAGES-1] ^ pol_reg;
  assign pending = ((mode_reg & pend_edge_reg) | (~mode_reg & act_reg)) & VALID;

  always_comb begin
    claim_id     = '0;
    claim_onehot = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pending[i] && enable_reg[i]) begin
        claim_id     = 6'(i + 1);
        claim_onehot = 32'b1 << i;
      end
    end
  end

  assign lane_bits = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign wr_mask   = lane_bits & VALID;
  assign wr_bits   = data_wr & wr_mask;
  assign rd_sample = read && !write && !rd_done_reg;
  assign stall     = rst_n && rd_sample;

`ifdef IRQC_SOFT_IRQ_EN
  assign soft_bits = (write && address == 3'd6) ? (wr_bits & mode_reg) : '0;
`else
  assign soft_bits = '0;
`endif

  assign set_bits = (act & ~act_reg & mode_reg) | soft_bits;
  assign clr_bits = ((write && address == 3'd0) ? wr_bits : '0)
                  | ((rd_sample && address == 3'd4) ? claim_onehot : '0);
  // Set beats clear; masking by the current mode drops edge state when a source goes level.
  assign pend_edge_next = ((pend_edge_reg & ~clr_bits) | set_bits) & mode_reg;

  always_comb begin
    rd_value = '0;
    case (address)
      3'd0:    rd_value = pending;
      3'd1:    rd_value = enable_reg;
      3'd2:    rd_value = mode_reg;
      3'd3:    rd_value = pol_reg;
      3'd4:    rd_value = {26'b0, claim_id};
      3'd5:    rd_value = act_reg;
      default: rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_reg    <= '0;
      mode_reg      <= RESET_MODE & VALID;
      pol_reg       <= '0;
      pend_edge_reg <= '0;
      act_reg       <= '0;
      irq_reg       <= 1'b0;
      rd_done_reg   <= 1'b0;
      data_rd_reg   <= '0;
    end else begin
      act_reg       <= act & VALID;
      pend_edge_reg <= pend_edge_next;
      irq_reg       <= |(pending & enable_reg);
      rd_done_reg   <= rd_sample;
      if (rd_sample) data_rd_reg <= rd_value;
      if (write) begin
        case (address)
          3'd1:    enable_reg <= (enable_reg & ~wr_mask) | wr_bits;
          3'd2:    mode_reg   <= (mode_reg & ~wr_mask) | wr_bits;
          3'd3:    pol_reg    <= (pol_reg & ~wr_mask) | wr_bits;
          default: ;
        endcase
      end
    end
  end

  assign data_rd   = data_rd_reg;
  assign interrupt = irq_reg ? (6'b1 << IRQ_LINE) : 6'b0;

endmodule
